// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter.
//   ADDR_W      : word-address width used by both request ports and the ROM
//   DATA_W      : instruction/data word width
//   ROM_LATENCY : cycles from rom_addr being sampled to rom_inst being valid
//   owner_e     : which port, if any, owns the ROM access issued this cycle
package imem_arbiter_pkg;

  localparam int unsigned ADDR_W      = 30;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ROM_LATENCY = 1;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } owner_e;

endpackage

// File: rtl/imem_starve_ctr.sv
// Counts consecutive cycles the data port has waited behind fetch.
//   clk, rst  : clock, synchronous active-high reset
//   wait_cyc  : data port is valid but was not granted this cycle
//   grant     : data port was granted this cycle
//   limit     : saturation value (1..15)
//   at_limit  : count has reached limit; data takes priority next
module imem_starve_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       wait_cyc,
  input  logic       grant,
  input  logic [3:0] limit,
  output logic       at_limit
);

  logic [3:0] cnt_q;

  // Any cycle that is not a wait (grant, or data idle) breaks the run.
  always_ff @(posedge clk) begin
    if (rst || grant || !wait_cyc) begin
      cnt_q <= 4'd0;
    end else if (cnt_q != limit) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/imem_arbiter.sv
// Two-port (fetch, data-read) arbiter in front of a single-cycle ROM.
// Fetch has priority unless the data port has waited STARVE_LIMIT cycles.
//   clk, rst                         : clock, synchronous active-high reset
//   f_req_valid/addr, f_req_ready    : fetch request handshake
//   f_resp_valid, f_resp_data        : fetch response, one cycle after grant
//   d_req_valid/addr, d_req_ready    : data request handshake
//   d_resp_valid, d_resp_data        : data response, one cycle after grant
//   rom_addr                         : address to ROM (registered inside ROM)
//   rom_inst                         : ROM word for last cycle's rom_addr
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  output logic              f_resp_valid,
  output logic [DATA_W-1:0] f_resp_data,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  output logic              d_req_ready,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  logic              at_limit;
  logic              f_gnt;
  logic              d_gnt;
  owner_e            owner_q;
  owner_e            owner_d;
  logic [ADDR_W-1:0] addr_q;

  always_comb begin
    f_gnt   = 1'b0;
    d_gnt   = 1'b0;
    owner_d = NONE;
    if (!rst) begin
      if (f_req_valid && !(d_req_valid && at_limit)) begin
        f_gnt   = 1'b1;
        owner_d = FETCH;
      end else if (d_req_valid) begin
        d_gnt   = 1'b1;
        owner_d = DATA;
      end
    end
  end

  // Forced to 0 during reset so a stale held address never leaks out.
  always_comb begin
    rom_addr = '0;
    if (!rst) begin
      if (f_gnt)      rom_addr = f_req_addr;
      else if (d_gnt) rom_addr = d_req_addr;
      else            rom_addr = addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= NONE;
      addr_q  <= '0;
    end else begin
      owner_q <= owner_d;
      if (f_gnt || d_gnt) addr_q <= rom_addr;
    end
  end

  imem_starve_ctr u_starve_ctr (
    .clk      (clk),
    .rst      (rst),
    .wait_cyc (d_req_valid && !d_gnt),
    .grant    (d_gnt),
    .limit    (4'(STARVE_LIMIT)),
    .at_limit (at_limit)
  );

  assign f_req_ready = f_gnt;
  assign d_req_ready = d_gnt;

  // Gating with rst drops a response whose grant landed just before reset.
  assign f_resp_valid = !rst && (owner_q == FETCH);
  assign d_resp_valid = !rst && (owner_q == DATA);
  assign f_resp_data  = f_resp_valid ? rom_inst : '0;
  assign d_resp_data  = d_resp_valid ? rom_inst : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  localparam int LIMIT = 4;
  localparam int ROM_WORDS = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req_valid = 1'b0;
  logic [29:0] f_req_addr = '0;
  logic        f_req_ready;
  logic        f_resp_valid;
  logic [31:0] f_resp_data;
  logic        d_req_valid = 1'b0;
  logic [29:0] d_req_addr = '0;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic [29:0] rom_addr;
  logic [31:0] rom_inst = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit done = 1'b0;

  logic [31:0] rom_mem [ROM_WORDS];

  typedef struct {
    int          due;
    logic        is_data;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  int          waited = 0;
  logic [29:0] last_addr = '0;

  imem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .f_req_valid  (f_req_valid),
    .f_req_addr   (f_req_addr),
    .f_req_ready  (f_req_ready),
    .f_resp_valid (f_resp_valid),
    .f_resp_data  (f_resp_data),
    .d_req_valid  (d_req_valid),
    .d_req_addr   (d_req_addr),
    .d_req_ready  (d_req_ready),
    .d_resp_valid (d_resp_valid),
    .d_resp_data  (d_resp_data),
    .rom_addr     (rom_addr),
    .rom_inst     (rom_inst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_word(input logic [29:0] a);
    if (a < 30'(ROM_WORDS)) return rom_mem[a[7:0]];
    return 32'h0;
  endfunction

  always @(posedge clk) rom_inst <= rom_word(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus plus the reference-model view of it.
  task automatic step(input logic r, input logic fv, input logic [29:0] fa,
                      input logic dv, input logic [29:0] da);
    logic ef, ed;
    logic [29:0] ea;
    @(posedge clk);
    #1;
    rst = r; f_req_valid = fv; f_req_addr = fa; d_req_valid = dv; d_req_addr = da;
    #2;
    ef = 1'b0; ed = 1'b0;
    if (r) begin
      waited = 0;
      last_addr = '0;
      ea = '0;
      while (exp_q.size() > 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
      chk("rst_resp_valid", {30'h0, f_resp_valid, d_resp_valid}, 32'h0);
    end else begin
      ef = fv && !(dv && waited == LIMIT);
      ed = dv && !ef;
      waited = (dv && !ed) ? ((waited < LIMIT) ? waited + 1 : LIMIT) : 0;
      if (ef) last_addr = fa;
      else if (ed) last_addr = da;
      ea = last_addr;
      if (ef || ed) exp_q.push_back('{due: cyc + 1, is_data: ed,
                                      data: rom_word(ef ? fa : da)});
    end
    chk("f_req_ready", {31'h0, f_req_ready}, {31'h0, ef});
    chk("d_req_ready", {31'h0, d_req_ready}, {31'h0, ed});
    chk("rom_addr", {2'b0, rom_addr}, {2'b0, ea});
  endtask

  // Response monitor: decoupled from stimulus, pops expectations as they fall due.
  always @(negedge clk) begin
    exp_t e;
    if (!done) begin
      if (f_resp_valid && d_resp_valid) chk("both_resp_valid", 32'h1, 32'h0);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        if (e.is_data) begin
          chk("d_resp_valid", {31'h0, d_resp_valid}, 32'h1);
          chk("d_resp_data", d_resp_data, e.data);
          chk("f_resp_data_idle", f_resp_data, 32'h0);
        end else begin
          chk("f_resp_valid", {31'h0, f_resp_valid}, 32'h1);
          chk("f_resp_data", f_resp_data, e.data);
          chk("d_resp_data_idle", d_resp_data, 32'h0);
        end
      end else begin
        chk("unexpected_resp", {30'h0, f_resp_valid, d_resp_valid}, 32'h0);
        chk("idle_resp_data", f_resp_data | d_resp_data, 32'h0);
      end
    end
  end

  initial begin
    for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = 32'(i) * 32'h9e3779b1 ^ 32'h1234abcd;
    rom_mem[0]     = 32'h3c1d1000;
    rom_mem[1]     = 32'h0c001403;
    rom_mem[2]     = 32'h37bd7000;
    rom_mem[3]     = 32'h27bdffc0;
    rom_mem[8'hc6] = 32'h27bdfff0;

    step(1, 1, 30'h5, 1, 30'h6);
    step(1, 1, 30'h5, 1, 30'h6);

    // Fetch 0..3 back-to-back
    for (int i = 0; i < 4; i++) step(0, 1, 30'(i), 0, '0);
    step(0, 0, '0, 0, '0);
    step(0, 0, '0, 0, '0);

    // Both valid continuously: 4 fetch grants then one data grant, repeating
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 30'(16 + i), 1, 30'(40 + i));
      chk("starve_pattern", {31'h0, d_req_ready}, {31'h0, (i % 5) == 4});
    end
    step(0, 0, '0, 0, '0);

    // Data only at 0xc6, then fetch at 0x12 and idle
    step(0, 0, '0, 1, 30'hc6);
    step(0, 1, 30'h12, 0, '0);
    step(0, 0, '0, 0, '0);
    step(0, 0, '0, 0, '0);
    chk("rom_addr_hold", {2'b0, rom_addr}, 32'h12);

    // Out-of-range data address
    step(0, 0, '0, 1, 30'h100);
    step(0, 0, '0, 0, '0);

    // Reset right after a grant, then fetch of 0 after release
    step(0, 1, 30'h2, 0, '0);
    step(1, 1, 30'h3, 1, 30'h3);
    step(0, 1, 30'h0, 0, '0);
    step(0, 0, '0, 0, '0);

    // Randomized traffic with occasional resets and in-range/out-of-range addresses
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 6), 30'($urandom_range(0, 300)),
           ($urandom_range(0, 9) < 7), 30'($urandom_range(0, 300)));
    end

    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, '0);
    @(posedge clk);
    #3;
    chk("drain", 32'(exp_q.size()), 32'h0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the consecutive data-port wait cycles (legal 1..15) before data overrides fetch priority.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 f_req_valid  in  1  fetch port request.
REQ-005 f_req_addr  in  30  fetch word address.
REQ-006 f_req_ready  out  1  fetch request accepted this cycle.
REQ-007 f_resp_valid  out  1  fetch response strobe.
REQ-008 f_resp_data  out  32  fetch instruction word.
REQ-009 d_req_valid  in  1  data-read port request.
REQ-010 d_req_addr  in  30  data-read word address.
REQ-011 d_req_ready  out  1  data request accepted this cycle.
REQ-012 d_resp_valid  out  1  data response strobe.
REQ-013 d_resp_data  out  32  data word.
REQ-014 rom_addr  out  30  address to instruction ROM (ROM registers it internally).
REQ-015 rom_inst  in  32  ROM word, valid the cycle after rom_addr is sampled.

Function
REQ-016 At most one request SHALL be accepted per cycle; acceptance = req_valid && req_ready in the same cycle.
REQ-017 Grant rule: fetch wins when both valid unless starve_cnt == STARVE_LIMIT, in which case data wins.
REQ-018 A lone valid requester SHALL be granted in the same cycle; ready SHALL be combinational from valid, rst and starve_cnt, and never asserted while rst is high.
REQ-019 rom_addr SHALL equal the granted address in a grant cycle, else the last granted address (held register, 0 after reset).
REQ-020 Latency: request accepted in cycle N SHALL produce resp_valid high for exactly one cycle in N+1 on the same port, with resp_data = rom_inst of cycle N+1.
REQ-021 resp_data of the non-responding port SHALL be 0; both resp_valid never high together.
REQ-022 Responses SHALL have no backpressure; back-to-back grants SHALL yield back-to-back responses (full throughput, one word per cycle).
REQ-023 starve_cnt (4 bits) SHALL increment when d_req_valid && !d_req_ready, saturate at STARVE_LIMIT, clear to 0 on data grant or when d_req_valid is low.
REQ-024 Owner register SHALL record the granted port (NONE/FETCH/DATA) for response routing; NONE when no grant.
REQ-025 Addresses SHALL pass unmodified (word addresses, no wrap or bounds check); out-of-range addresses return whatever rom_inst supplies (0 from default ROM entries).
REQ-026 Requester changing addr while valid and not ready SHALL be allowed; the address sampled at grant is the one served.

Reset
REQ-027 While rst is high: f/d_req_ready = 0, f/d_resp_valid = 0, resp_data = 0, rom_addr = 0, owner = NONE, starve_cnt = 0.
REQ-028 A request accepted in the cycle before rst rises SHALL have its response suppressed; no response is emitted in the first cycle after rst falls.
REQ-029 Requests pending during rst SHALL be considered from the first cycle rst is low with starve_cnt = 0.

Structure
REQ-030 Shared package SHALL hold ADDR_W = 30, DATA_W = 32, ROM_LATENCY = 1, and the owner enum (NONE, FETCH, DATA).
REQ-031 Starvation counter SHALL be one sub-module, imem_starve_ctr (inputs wait, grant, limit; output at_limit).
REQ-032 Grant logic and response routing remain in imem_arbiter; ROM instantiated by the bench/top, not inside.

Verification
REQ-033 Fetch only, addr 0x0..0x3 back-to-back -> f_resp_data 0x3c1d1000, 0x0c001403, 0x37bd7000, 0x27bdffc0 on consecutive cycles, one cycle after each grant.
REQ-034 Both valid continuously, STARVE_LIMIT=4 -> fetch granted 4 cycles, data granted cycle 5, counter clears, pattern repeats (4:1).
REQ-035 Data only, addr 0xc6 -> d_resp_valid one cycle later, d_resp_data 0x27bdfff0, f_resp_valid stays 0.
REQ-036 Fetch granted at addr 0x12, then idle -> rom_addr holds 0x12, no further resp_valid.
REQ-037 rst asserted the cycle after a grant -> no resp_valid, all outputs 0; after release first fetch of 0x0 returns 0x3c1d1000.
REQ-038 Out-of-range addr 0x100 on data port -> d_resp_data 0x00000000, grant and latency unchanged.
